// File: rtl/nand_sweep_checker_pkg.sv
// Shared definitions for the gate sweep checkers: FSM state encoding,
// settle-timer width and the expected-output function.
package nand_sweep_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int unsigned TIMER_W = 4;

    // Only the low n bits of vec take part; expect_nand selects NAND vs AND.
    function automatic logic expect_fn(input logic [7:0] vec,
                                       input int unsigned n,
                                       input logic expect_nand);
        logic all_ones;
        all_ones = 1'b1;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < n) all_ones = all_ones & vec[i];
        end
        return expect_nand ? ~all_ones : all_ones;
    endfunction

endpackage

// File: rtl/nand_sweep_checker_settle_timer.sv
// Load/decrement settle counter; EXPIRE is high while the count equals 1.
module settle_timer
    import nand_sweep_checker_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               LOAD,
    input  logic [TIMER_W-1:0] LOAD_VAL,
    output logic               EXPIRE
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (LOAD) begin
            count_d = LOAD_VAL;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign EXPIRE = (count_q == TIMER_W'(1));

endmodule

// File: rtl/nand_sweep_checker.sv
// Exhaustive stimulus/check engine for an N-input NAND or AND gate:
// drives every vector, samples Y_IN after a settle window, scores mismatches.
module nand_sweep_checker
    import nand_sweep_checker_pkg::*;
#(
    parameter int unsigned N             = 2,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter bit          EXPECT_NAND   = 1'b1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    output logic [N-1:0] A,
    input  logic         Y_IN,
    output logic         BUSY,
    output logic         DONE,
    output logic         PASS,
    output logic [N:0]   ERR_COUNT,
    output logic [N-1:0] FAIL_VEC
);

    state_t       state_q;
    logic [N-1:0] vec_q;
    logic [N-1:0] a_q;
    logic [N-1:0] fail_vec_q;
    logic [N:0]   err_q;
    logic         busy_q;
    logic         done_q;
    logic         pass_q;

    logic         expected;
    logic         mismatch;
    logic         settle_expire;

    settle_timer u_settle_timer (
        .CLK      (CLK),
        .RST      (RST),
        .LOAD     (state_q == ST_DRIVE),
        .LOAD_VAL (TIMER_W'(SETTLE_CYCLES)),
        .EXPIRE   (settle_expire)
    );

    // An X/Z on Y_IN must count as a failure in simulation.
    always_comb begin
        expected = expect_fn(8'(vec_q), N, EXPECT_NAND);
`ifdef SYNTHESIS
        mismatch = (Y_IN != expected);
`else
        mismatch = (Y_IN !== expected);
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            vec_q      <= '0;
            a_q        <= '0;
            fail_vec_q <= '0;
            err_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        err_q      <= '0;
                        fail_vec_q <= '0;
                        pass_q     <= 1'b0;
                        done_q     <= 1'b0;
                        vec_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    a_q     <= vec_q;
                    state_q <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_expire) state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        err_q <= err_q + 1'b1;
                        if (err_q == '0) fail_vec_q <= vec_q;
                    end
                    if (vec_q == {N{1'b1}}) begin
                        a_q     <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_q == '0) && !mismatch;
                        state_q <= ST_DONE;
                    end else begin
                        vec_q   <= vec_q + 1'b1;
                        state_q <= ST_DRIVE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign A         = a_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign PASS      = pass_q;
    assign ERR_COUNT = err_q;
    assign FAIL_VEC  = fail_vec_q;

endmodule

// File: tb/tb_nand_sweep_checker.sv
// Bench for nand_sweep_checker: timeline model of the main N=2/S=1 instance
// checked every cycle, plus literal end-of-sweep expectations.
module tb_nand_sweep_checker;

    localparam int unsigned N  = 2;
    localparam int unsigned S  = 1;
    localparam int unsigned EW = N + 1;

    logic CLK       = 1'b0;
    logic RST       = 1'b0;
    logic START     = 1'b0;
    logic start_aux = 1'b0;
    logic [1:0] mode = 2'd0;   // 0: NAND gate, 1: stuck-at-1, 2: AND gate

    logic [N-1:0] A;
    logic         Y_IN;
    logic         BUSY, DONE, PASS;
    logic [N:0]   ERR_COUNT;
    logic [N-1:0] FAIL_VEC;

    always #5 CLK = ~CLK;

    assign Y_IN = (mode == 2'd0) ? ~&A : (mode == 2'd1) ? 1'b1 : &A;

    nand_sweep_checker #(.N(2), .SETTLE_CYCLES(1), .EXPECT_NAND(1'b1)) dut (
        .CLK(CLK), .RST(RST), .START(START), .A(A), .Y_IN(Y_IN),
        .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .ERR_COUNT(ERR_COUNT), .FAIL_VEC(FAIL_VEC)
    );

    logic [1:0] a_and, fv_and;
    logic [2:0] err_and;
    logic       busy_and, done_and, pass_and;
    nand_sweep_checker #(.N(2), .SETTLE_CYCLES(1), .EXPECT_NAND(1'b0)) dut_and (
        .CLK(CLK), .RST(RST), .START(start_aux), .A(a_and), .Y_IN(&a_and),
        .BUSY(busy_and), .DONE(done_and), .PASS(pass_and), .ERR_COUNT(err_and), .FAIL_VEC(fv_and)
    );

    logic [2:0] a3, fv3, a3b, fv3b;
    logic [3:0] err3, err3b;
    logic       busy3, done3, pass3, busy3b, done3b, pass3b;
    logic       y3_d1 = 1'b1, y3_d2 = 1'b1, yb_d1 = 1'b1, yb_d2 = 1'b1;

    always @(posedge CLK) begin
        y3_d1 <= ~&a3;
        y3_d2 <= y3_d1;
        yb_d1 <= ~&a3b;
        yb_d2 <= yb_d1;
    end

    nand_sweep_checker #(.N(3), .SETTLE_CYCLES(3), .EXPECT_NAND(1'b1)) dut_n3s3 (
        .CLK(CLK), .RST(RST), .START(start_aux), .A(a3), .Y_IN(y3_d2),
        .BUSY(busy3), .DONE(done3), .PASS(pass3), .ERR_COUNT(err3), .FAIL_VEC(fv3)
    );

    nand_sweep_checker #(.N(3), .SETTLE_CYCLES(1), .EXPECT_NAND(1'b1)) dut_n3s1 (
        .CLK(CLK), .RST(RST), .START(start_aux), .A(a3b), .Y_IN(yb_d2),
        .BUSY(busy3b), .DONE(done3b), .PASS(pass3b), .ERR_COUNT(err3b), .FAIL_VEC(fv3b)
    );

    int checks   = 0;
    int failures = 0;
    bit model_on = 1'b0;

    // Timeline model: each vector occupies S+2 cycles after the START edge;
    // A updates on the first cycle of a slot, Y_IN is judged on the last.
    bit           m_busy = 1'b0, m_done = 1'b0, m_pass = 1'b0;
    int unsigned  m_t = 0, m_err = 0, m_vec = 0, m_phase = 0;
    logic [N-1:0] m_a = '0, m_fail = '0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_busy = 1'b0; m_done = 1'b0; m_pass = 1'b0;
            m_t = 0; m_err = 0; m_a = '0; m_fail = '0;
        end else if (!m_busy) begin
            if (START) begin
                m_busy = 1'b1; m_done = 1'b0; m_pass = 1'b0;
                m_t = 0; m_err = 0; m_fail = '0;
            end
        end else begin
            m_vec   = m_t / (S + 2);
            m_phase = m_t % (S + 2);
            if (m_phase == 0) m_a = N'(m_vec);
            if (m_phase == S + 1) begin
                if (Y_IN !== ~&(N'(m_vec))) begin
                    if (m_err == 0) m_fail = N'(m_vec);
                    m_err++;
                end
                if (m_vec == (1 << N) - 1) begin
                    m_busy = 1'b0; m_done = 1'b1; m_pass = (m_err == 0); m_a = '0;
                end
            end
            m_t++;
        end
    end

    initial forever begin
        @(negedge CLK);
        if (model_on && !RST) begin
            checks++;
            if ({A, BUSY, DONE, PASS, ERR_COUNT, FAIL_VEC} !==
                {m_a, m_busy, m_done, m_pass, EW'(m_err), m_fail}) begin
                failures++;
                $display("FAIL model_cmp t=%0t A=%0d/%0d BUSY=%0b/%0b DONE=%0b/%0b PASS=%0b/%0b ERR=%0d/%0d FAILVEC=%0d/%0d (actual/required)",
                         $time, A, m_a, BUSY, m_busy, DONE, m_done, PASS, m_pass,
                         ERR_COUNT, m_err, FAIL_VEC, m_fail);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    logic [N-1:0] a_hist [256];
    int           busy_cnt;

    task automatic run_sweep(input bit mid_start);
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check("restart_err_clear", 32'(ERR_COUNT), 0);
        check("start_busy", 32'(BUSY), 1);
        busy_cnt = 0;
        while (BUSY && busy_cnt < 200) begin
            a_hist[busy_cnt] = A;
            busy_cnt++;
            @(negedge CLK);
            START = mid_start && (busy_cnt == 3 || busy_cnt == 6);
        end
        START = 1'b0;
        check("sweep_timeout", 32'(BUSY), 0);
    endtask

    initial begin
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        model_on = 1'b1;
        check("reset_A", 32'(A), 0);
        check("reset_BUSY", 32'(BUSY), 0);
        check("reset_DONE", 32'(DONE), 0);
        check("reset_PASS", 32'(PASS), 0);
        check("reset_ERR", 32'(ERR_COUNT), 0);
        check("reset_FAILVEC", 32'(FAIL_VEC), 0);

        mode = 2'd0;
        run_sweep(1'b0);
        check("nand_busy_cycles", 32'(busy_cnt), 12);
        check("nand_A_slot0", 32'(a_hist[1]), 0);
        check("nand_A_slot1", 32'(a_hist[4]), 1);
        check("nand_A_slot2", 32'(a_hist[7]), 2);
        check("nand_A_slot3", 32'(a_hist[10]), 3);
        check("nand_DONE", 32'(DONE), 1);
        check("nand_PASS", 32'(PASS), 1);
        check("nand_ERR", 32'(ERR_COUNT), 0);
        check("nand_A_done", 32'(A), 0);

        mode = 2'd1;
        run_sweep(1'b0);
        check("stuck1_DONE", 32'(DONE), 1);
        check("stuck1_PASS", 32'(PASS), 0);
        check("stuck1_ERR", 32'(ERR_COUNT), 1);
        check("stuck1_FAILVEC", 32'(FAIL_VEC), 3);

        mode = 2'd2;
        run_sweep(1'b0);
        check("andgate_ERR", 32'(ERR_COUNT), 4);
        check("andgate_FAILVEC", 32'(FAIL_VEC), 0);
        check("andgate_PASS", 32'(PASS), 0);

        mode = 2'd0;
        run_sweep(1'b1);
        check("midstart_busy_cycles", 32'(busy_cnt), 12);
        check("midstart_PASS", 32'(PASS), 1);
        check("midstart_ERR", 32'(ERR_COUNT), 0);

        mode = 2'd2;
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (7) @(negedge CLK);
        check("prereset_A", 32'(A), 2);
        check("prereset_ERR", 32'(ERR_COUNT), 2);
        #2 RST = 1'b1;
        #1;
        check("async_rst_A", 32'(A), 0);
        check("async_rst_BUSY", 32'(BUSY), 0);
        check("async_rst_DONE", 32'(DONE), 0);
        check("async_rst_PASS", 32'(PASS), 0);
        check("async_rst_ERR", 32'(ERR_COUNT), 0);
        check("async_rst_FAILVEC", 32'(FAIL_VEC), 0);
        @(negedge CLK);
        RST = 1'b0;
        mode = 2'd0;
        run_sweep(1'b0);
        check("postrst_A_slot0", 32'(a_hist[1]), 0);
        check("postrst_A_slot1", 32'(a_hist[4]), 1);
        check("postrst_PASS", 32'(PASS), 1);

        @(negedge CLK);
        start_aux = 1'b1;
        @(negedge CLK);
        start_aux = 1'b0;
        busy_cnt = 0;
        while (busy3 && busy_cnt < 500) begin
            busy_cnt++;
            @(negedge CLK);
        end
        check("n3s3_busy_cycles", 32'(busy_cnt), 40);
        check("n3s3_DONE", 32'(done3), 1);
        check("n3s3_PASS", 32'(pass3), 1);
        check("n3s3_ERR", 32'(err3), 0);
        check("n3s1_DONE", 32'(done3b), 1);
        check("n3s1_PASS", 32'(pass3b), 0);
        check("n3s1_ERR", 32'(err3b), 1);
        check("n3s1_FAILVEC", 32'(fv3b), 7);
        check("andexp_DONE", 32'(done_and), 1);
        check("andexp_PASS", 32'(pass_and), 1);
        check("andexp_ERR", 32'(err_and), 0);

        repeat (2) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
